fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of the instruction memory and feeds decode.
- Owns the program counter and drives the byte address into the combinational instruction ROM (word-indexed by addr[11:2]).
- Captures the returned instruction word into an IF/ID register with a valid/ready handshake toward decode.
- Handles branch redirect, flush, backpressure and illegal fetch addresses.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- ROM_WORDS, 64: instruction memory depth in words; legal fetch range is [0, ROM_WORDS*4).
- CNT_W, 32: width of the delivered-instruction counter.

Ports:
- clk  in  1: single clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- imem_addr  out  32: byte address to instruction memory.
- imem_rd  in  32: instruction word returned combinationally for imem_addr.
- redirect_i  in  1: branch/jump taken; load redirect_target_i.
- redirect_target_i  in  32: new PC (byte address).
- flush_i  in  1: invalidate the IF/ID register without changing the PC.
- id_ready_i  in  1: decode accepts the IF/ID contents this cycle.
- id_valid_o  out  1: IF/ID holds a valid instruction.
- id_instr_o  out  32: fetched instruction.
- id_pc_o  out  32: PC of id_instr_o.
- id_pc_plus4_o  out  32: id_pc_o + 4.
- fault_o  out  1: sticky fetch fault (misaligned or out-of-range PC).
- instr_count_o  out  CNT_W: number of instructions accepted by decode (valid && ready).

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - pc_q = RESET_PC; state = S_BOOT; id_valid_o = 0; id_instr_o = NOP (32'h0); id_pc_o = 0; id_pc_plus4_o = 4.
  - fault_o = 0; instr_count_o = 0.
- imem_addr = pc_q, driven combinationally in all states.
- States:
  - S_BOOT: one bubble cycle with no capture; next state is S_FETCH unconditionally.
  - S_FETCH: normal operation, with the per-cycle priority below.
  - S_FAULT: terminal; exit only via reset.
- Per-cycle priority in S_FETCH:
  1. redirect_i:
     - If redirect_target_i[1:0] != 0 or redirect_target_i >= ROM_WORDS*4: go to S_FAULT, set fault_o = 1, clear id_valid_o, hold pc_q.
     - Otherwise: pc_q <= redirect_target_i and id_valid_o <= 0 (the wrong-path instruction is dropped).
     - Redirect overrides both backpressure and flush.
  2. flush_i: id_valid_o <= 0; pc_q holds. The next cycle fetches the same pc_q again.
  3. Stall (id_valid_o && !id_ready_i): pc_q and all IF/ID outputs hold stable.
  4. Advance (otherwise):
     - If pc_q >= ROM_WORDS*4: go to S_FAULT, set fault_o = 1, id_valid_o <= 0.
     - Else: id_instr_o <= imem_rd, id_pc_o <= pc_q, id_pc_plus4_o <= pc_q + 4, id_valid_o <= 1, pc_q <= pc_q + 4.
- Latency: an instruction at address A appears on id_instr_o one clock after pc_q == A.
- Throughput: one instruction per cycle while id_ready_i = 1.
- instr_count_o increments by 1 on every cycle with id_valid_o && id_ready_i and no redirect_i/flush_i. It wraps at 2^CNT_W.
- In S_FAULT:
  - id_valid_o = 0; imem_addr keeps the last pc_q.
  - redirect_i, flush_i and id_ready_i are ignored.
- PC arithmetic is modulo 2^32. A range fault is raised before any 32-bit wrap can occur when ROM_WORDS*4 < 2^32.
- Reset asserted mid-operation: all state returns to reset values immediately; pending IF/ID contents are discarded.

Decomposition:
- Package fetch_pkg:
  - enum fetch_state_t {S_BOOT, S_FETCH, S_FAULT}.
  - localparam NOP_INSTR = 32'h0.
  - localparam PC_STEP = 4.
  - function is_legal_pc(addr, rom_words), covering the alignment and range check.
- One sub-module, pc_reg: holds pc_q and selects between hold, +4 and redirect. The IF/ID register, FSM and counter stay in fetch_stage.

Test Plan:
- Reset then release, id_ready_i = 1, ROM words 0..2 = 32'hE3A00001, 32'hE3A01002, 32'hE0802001 -> cycle 1 bubble; cycles 2–4 give id_valid_o = 1 with id_pc_o = 0, 4, 8 and matching instructions; instr_count_o = 3.
- Hold id_ready_i = 0 for 3 cycles while id_pc_o = 4 -> id_instr_o, id_pc_o and imem_addr = 8 stay stable; release gives id_pc_o = 8 next cycle.
- redirect_i with target 32'h20 while stalled -> next cycle id_valid_o = 0, imem_addr = 32'h20; following cycle id_pc_o = 32'h20, and the counter does not count the dropped instruction.
- redirect_i with target 32'h22 -> fault_o = 1 and id_valid_o = 0 from the next cycle on; stays so for 10 cycles despite further redirects.
- Straight-line run from RESET_PC = 32'hF8 with ROM_WORDS = 64 -> PCs 0xF8 and 0xFC delivered; at pc_q = 0x100, fault_o = 1 with no capture.
- Assert rst_n low mid-stream between clock edges -> outputs reach reset values without waiting for a clock edge; after release, the fetch sequence restarts at RESET_PC with one bubble.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types, constants and the fetch-address legality check for the fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_FAULT} fetch_state_t;
  typedef enum logic [1:0] {PC_HOLD, PC_INC, PC_LOAD} pc_sel_t;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Widened compare so a huge rom_words cannot wrap the byte limit.
  function automatic logic is_legal_pc(input logic [31:0] addr, input int unsigned rom_words);
    logic [33:0] limit;
    limit = 34'(rom_words) << 2;
    return (addr[1:0] == 2'b00) && ({2'b00, addr} < limit);
  endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register: holds, steps by one word, or loads a redirect target.
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  pc_sel_t     sel,
  input  logic [31:0] target,
  output logic [31:0] pc_q
);

  // NOTE: state registers use non-blocking assignments and an async reset in the sensitivity list.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      case (sel)
        PC_INC:  pc_q <= pc_q + PC_STEP;
        PC_LOAD: pc_q <= target;
        default: pc_q <= pc_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, IF/ID register with valid/ready, redirect/flush and fault.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_WORDS = 64,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rd,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_target_i,
  input  logic             flush_i,
  input  logic             id_ready_i,
  output logic             id_valid_o,
  output logic [31:0]      id_instr_o,
  output logic [31:0]      id_pc_o,
  output logic [31:0]      id_pc_plus4_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] instr_count_o
);

  fetch_state_t state;
  pc_sel_t      pc_sel;
  logic [31:0]  pc_q;
  logic         redirect_ok;
  logic         pc_ok;
  logic         stall;
  logic         count_en;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .sel    (pc_sel),
    .target (redirect_target_i),
    .pc_q   (pc_q)
  );

  assign imem_addr = pc_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    redirect_ok = is_legal_pc(redirect_target_i, ROM_WORDS);
    pc_ok       = is_legal_pc(pc_q, ROM_WORDS);
    stall       = id_valid_o && !id_ready_i;
    count_en    = (state == S_FETCH) && id_valid_o && id_ready_i && !redirect_i && !flush_i;
    pc_sel      = PC_HOLD;
    if (state == S_FETCH) begin
      if (redirect_i) begin
        if (redirect_ok) pc_sel = PC_LOAD;
      end else if (!flush_i && !stall && pc_ok) begin
        pc_sel = PC_INC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_BOOT;
      id_valid_o    <= 1'b0;
      id_instr_o    <= NOP_INSTR;
      id_pc_o       <= 32'h0;
      id_pc_plus4_o <= PC_STEP;
      fault_o       <= 1'b0;
      instr_count_o <= '0;
    end else begin
      if (count_en) instr_count_o <= instr_count_o + CNT_W'(1);
      case (state)
        S_BOOT: state <= S_FETCH;
        S_FETCH: begin
          // Redirect beats flush and backpressure; the wrong-path word is dropped.
          if (redirect_i) begin
            id_valid_o <= 1'b0;
            if (!redirect_ok) begin
              state   <= S_FAULT;
              fault_o <= 1'b1;
            end
          end else if (flush_i) begin
            id_valid_o <= 1'b0;
          end else if (!stall) begin
            if (!pc_ok) begin
              state      <= S_FAULT;
              fault_o    <= 1'b1;
              id_valid_o <= 1'b0;
            end else begin
              id_instr_o    <= imem_rd;
              id_pc_o       <= pc_q;
              id_pc_plus4_o <= pc_q + PC_STEP;
              id_valid_o    <= 1'b1;
            end
          end
        end
        default: id_valid_o <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized bench for fetch_stage against a cycle-level behavioural model.
module tb_fetch_stage;

  localparam int          ROM_WORDS = 64;
  localparam logic [31:0] ROM_BYTES = 32'd256;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] rom [ROM_WORDS];

  // Main DUT (RESET_PC = 0)
  logic [31:0] imem_addr, imem_rd, redirect_target_i;
  logic        redirect_i, flush_i, id_ready_i;
  logic        id_valid_o, fault_o;
  logic [31:0] id_instr_o, id_pc_o, id_pc_plus4_o, instr_count_o;

  // Second DUT starting near the top of the ROM, free-running
  logic [31:0] h_addr, h_rd, h_instr, h_pc, h_pc4, h_count;
  logic        h_valid, h_fault;
  logic        h_redirect = 1'b0, h_flush = 1'b0, h_ready = 1'b1;
  logic [31:0] h_target = 32'h0;

  assign imem_rd = (imem_addr < ROM_BYTES) ? rom[imem_addr[7:2]] : 32'hDEAD_BEEF;
  assign h_rd    = (h_addr < ROM_BYTES) ? rom[h_addr[7:2]] : 32'hDEAD_BEEF;

  fetch_stage #(.RESET_PC(32'h0), .ROM_WORDS(ROM_WORDS), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .redirect_i(redirect_i), .redirect_target_i(redirect_target_i), .flush_i(flush_i),
    .id_ready_i(id_ready_i), .id_valid_o(id_valid_o), .id_instr_o(id_instr_o),
    .id_pc_o(id_pc_o), .id_pc_plus4_o(id_pc_plus4_o), .fault_o(fault_o),
    .instr_count_o(instr_count_o)
  );

  fetch_stage #(.RESET_PC(32'hF8), .ROM_WORDS(ROM_WORDS), .CNT_W(32)) dut_hi (
    .clk(clk), .rst_n(rst_n), .imem_addr(h_addr), .imem_rd(h_rd),
    .redirect_i(h_redirect), .redirect_target_i(h_target), .flush_i(h_flush),
    .id_ready_i(h_ready), .id_valid_o(h_valid), .id_instr_o(h_instr),
    .id_pc_o(h_pc), .id_pc_plus4_o(h_pc4), .fault_o(h_fault),
    .instr_count_o(h_count)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model of the main DUT
  bit          m_boot, m_fault, m_valid;
  logic [31:0] m_pc, m_instr, m_id_pc, m_count;

  task automatic model_reset();
    m_boot = 1; m_fault = 0; m_valid = 0;
    m_pc = 32'h0; m_instr = 32'h0; m_id_pc = 32'h0; m_count = 32'h0;
  endtask

  task automatic model_step();
    if (m_boot) begin
      m_boot = 0;
    end else if (!m_fault) begin
      if (redirect_i) begin
        m_valid = 0;
        if (redirect_target_i % 4 != 0 || redirect_target_i >= ROM_BYTES) m_fault = 1;
        else m_pc = redirect_target_i;
      end else if (flush_i) begin
        m_valid = 0;
      end else if (!(m_valid && !id_ready_i)) begin
        if (m_valid) m_count = m_count + 1;
        if (m_pc >= ROM_BYTES) begin
          m_fault = 1;
          m_valid = 0;
        end else begin
          m_instr = rom[m_pc / 4];
          m_id_pc = m_pc;
          m_valid = 1;
          m_pc    = m_pc + 4;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string w);
    check({w, ".imem_addr"}, imem_addr, m_pc);
    check({w, ".valid"}, 32'(id_valid_o), 32'(m_valid));
    check({w, ".instr"}, id_instr_o, m_instr);
    check({w, ".id_pc"}, id_pc_o, m_id_pc);
    check({w, ".pc_plus4"}, id_pc_plus4_o, m_id_pc + 32'd4);
    check({w, ".fault"}, 32'(fault_o), 32'(m_fault));
    check({w, ".count"}, instr_count_o, m_count);
  endtask

  task automatic tick(input string w);
    @(posedge clk);
    model_step();
    #1;
    check_all(w);
  endtask

  task automatic idle_inputs();
    redirect_i = 0; redirect_target_i = 32'h0; flush_i = 0; id_ready_i = 1;
  endtask

  // Asserts reset between clock edges and checks outputs before any edge arrives.
  task automatic async_reset(input string w);
    idle_inputs();
    #3 rst_n = 0;
    #1 model_reset();
    check_all(w);
    check({w, ".valid0"}, 32'(id_valid_o), 32'h0);
    check({w, ".plus4_4"}, id_pc_plus4_o, 32'h4);
    #2 rst_n = 1;
  endtask

  logic [31:0] saved_count;

  initial begin
    for (int i = 0; i < ROM_WORDS; i++) rom[i] = $urandom;
    rom[0] = 32'hE3A00001;
    rom[1] = 32'hE3A01002;
    rom[2] = 32'hE0802001;
    idle_inputs();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check("reset.hi_addr", h_addr, 32'hF8);
    check("reset.hi_fault", 32'(h_fault), 32'h0);
    rst_n = 1;

    // Boot bubble, then in-order delivery
    tick("boot");
    check("boot.bubble", 32'(id_valid_o), 32'h0);
    check("boot.hi_bubble", 32'(h_valid), 32'h0);
    tick("seq0");
    check("seq0.pc", id_pc_o, 32'h0);
    check("seq0.instr", id_instr_o, 32'hE3A00001);
    check("seq0.hi_pc", h_pc, 32'hF8);
    check("seq0.hi_instr", h_instr, rom[62]);
    tick("seq1");
    check("seq1.pc", id_pc_o, 32'h4);
    check("seq1.instr", id_instr_o, 32'hE3A01002);
    check("seq1.hi_pc", h_pc, 32'hFC);
    check("seq1.hi_pc4", h_pc4, 32'h100);

    // Backpressure for three cycles
    id_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      check("stall.pc", id_pc_o, 32'h4);
      check("stall.addr", imem_addr, 32'h8);
      if (i == 0) begin
        check("hi_range.fault", 32'(h_fault), 32'h1);
        check("hi_range.valid", 32'(h_valid), 32'h0);
        check("hi_range.addr", h_addr, 32'h100);
        check("hi_range.count", h_count, 32'h2);
      end
    end
    id_ready_i = 1;
    tick("release");
    check("release.pc", id_pc_o, 32'h8);
    check("release.instr", id_instr_o, 32'hE0802001);

    // Redirect while stalled drops the held instruction without counting it
    id_ready_i = 0;
    tick("pre_redir");
    saved_count = instr_count_o;
    redirect_i = 1; redirect_target_i = 32'h20; id_ready_i = 1;
    tick("redir");
    check("redir.valid", 32'(id_valid_o), 32'h0);
    check("redir.addr", imem_addr, 32'h20);
    check("redir.count", instr_count_o, saved_count);
    redirect_i = 0;
    tick("redir_land");
    check("redir_land.pc", id_pc_o, 32'h20);
    check("redir_land.count", instr_count_o, saved_count);

    // Flush holds the PC and refetches it
    flush_i = 1;
    tick("flush");
    check("flush.valid", 32'(id_valid_o), 32'h0);
    check("flush.addr", imem_addr, 32'h24);
    flush_i = 0;
    tick("refetch");
    check("refetch.pc", id_pc_o, 32'h24);

    // Randomized traffic with legal redirects
    for (int i = 0; i < 400; i++) begin
      redirect_i        = ($urandom_range(0, 9) == 0);
      redirect_target_i = 32'($urandom_range(0, ROM_WORDS - 1)) * 32'd4;
      flush_i           = ($urandom_range(0, 9) == 0);
      id_ready_i        = ($urandom_range(0, 3) != 0);
      tick("rand");
    end

    // Mid-stream async reset, restart with one bubble
    async_reset("async_rst");
    tick("restart_bubble");
    check("restart.bubble", 32'(id_valid_o), 32'h0);
    tick("restart0");
    check("restart0.pc", id_pc_o, 32'h0);
    check("restart0.instr", id_instr_o, 32'hE3A00001);

    // Misaligned redirect faults; fault is terminal
    redirect_i = 1; redirect_target_i = 32'h22;
    tick("misalign");
    check("misalign.fault", 32'(fault_o), 32'h1);
    for (int i = 0; i < 10; i++) begin
      redirect_i        = $urandom_range(0, 1);
      redirect_target_i = 32'($urandom_range(0, ROM_WORDS - 1)) * 32'd4;
      flush_i           = $urandom_range(0, 1);
      id_ready_i        = $urandom_range(0, 1);
      tick("fault_hold");
      check("fault_hold.fault", 32'(fault_o), 32'h1);
      check("fault_hold.valid", 32'(id_valid_o), 32'h0);
    end

    // Aligned but out-of-range redirect also faults
    async_reset("async_rst2");
    tick("boot2");
    tick("run2");
    redirect_i = 1; redirect_target_i = ROM_BYTES;
    tick("range_redir");
    check("range_redir.fault", 32'(fault_o), 32'h1);
    idle_inputs();
    tick("range_hold");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
